qmem_boot_seq: RTL and testbench
================================

Name: qmem_boot_seq

Overview:
- Boot-time sequencer that fills the instruction QMEM through the 32-bit initram write port (addr/data/byte_en/stb), ahead of the endianness/width adaptation stage.
- Copies a block of words from a handshaked boot source (flash/ROM reader) into QMEM.
- Arbitrates a second requester, a debug host single-word write port, onto the same initram port.
- Holds the CPU in reset until the copy completes.

Parameters:
- SRC_BASE, 32'h0000_0000, byte address of first source word.
- DST_BASE, 32'h0000_0000, byte address of first QMEM destination word.
- CNT_W, 16, width of the word-count and index.
- TIMEOUT, 255, max cycles src_req may wait for src_ack; must be ≥1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle copy request.
- len  in  CNT_W  words to copy; sampled with start.
- src_req  out  1  source read request.
- src_addr  out  32  source byte address.
- src_ack  in  1  source data valid (single cycle).
- src_data  in  32  source word.
- host_stb  in  1  host write request; level, held until host_ack.
- host_addr  in  32  host byte address.
- host_data  in  32  host write data.
- host_byte_en  in  4  host byte enables.
- host_ack  out  1  host write accepted (single cycle).
- initram_stb  out  1  QMEM write strobe (single cycle).
- initram_addr  out  32  QMEM byte address.
- initram_data  out  32  QMEM write data.
- initram_byte_en  out  4  QMEM byte enables.
- busy  out  1  copy in progress.
- done  out  1  copy completed (sticky).
- err  out  1  source timeout (sticky).
- cpu_rst_n  out  1  CPU reset release, active-low.

Behaviour:
- **Outputs:** all registered.
- **Reset values:** every output 0, including cpu_rst_n=0 (CPU held in reset); idx=0; timer=0; state IDLE.

- **FSM states:** IDLE, FETCH, WRITE, HOST, DONE, ERR.

- **start acceptance:** start is accepted only in IDLE, DONE or ERR. On acceptance:
  - latch len; idx=0;
  - clear done and err; drive cpu_rst_n=0;
  - if len==0, go to DONE next cycle;
  - otherwise go to FETCH.
- **start elsewhere:** ignored in FETCH, WRITE and HOST.
- **start vs host_stb:** when both are pending in the same cycle, start wins.

- **FETCH:**
  - src_req=1; src_addr=SRC_BASE+4*idx (mod 2^32); timer increments each cycle.
  - src_ack=1: latch src_data, clear src_req and timer, go to WRITE.
  - timer reaches TIMEOUT without ack: clear src_req, set err=1, go to ERR.
- **WRITE (one cycle):**
  - initram_stb=1; initram_addr=DST_BASE+4*idx (mod 2^32); initram_data=latched word; initram_byte_en=4'hF; idx++.
  - If the new idx==len: go to DONE.
  - Otherwise, if host_stb=1: go to HOST. Else go to FETCH.
- **HOST (one cycle):**
  - initram_stb=1 with host_addr/host_data/host_byte_en; host_ack=1 in the same cycle.
  - Return to FETCH if a copy is active; otherwise return to the originating IDLE, DONE or ERR.
  - Effect: at most one host write is interleaved between consecutive copy words.
- **Host from idle states:** in IDLE, DONE or ERR, host_stb=1 (and no start) enters HOST. Host writes are never lost while held.
- **initram_stb:** never asserted outside WRITE and HOST. Worst-case back-to-back strobes are WRITE→HOST.
- **Copy latency:** per word is (src_ack wait + 2) cycles.
- **busy:** 1 in FETCH, WRITE, and HOST-within-copy.
- **DONE:** done=1; cpu_rst_n=1.
- **ERR:** err=1; cpu_rst_n stays 0.
- **src_ack:** ignored outside FETCH.
- **Reset mid-copy:** immediate return to reset values; a partially written QMEM is not restored.

Test Plan:
- **Basic copy:** len=4, SRC_BASE=0x100, DST_BASE=0x2000, src_ack 2 cycles after each req → initram_stb at addr 0x2000/04/08/0C carrying source words, byte_en=F; done=1 and cpu_rst_n=1 the cycle after the 4th write.
- **Interleaved host write:** host_stb held from copy start, addr 0x3000, data 0xDEADBEEF, byte_en 4'b0011 → exactly one host write after each copy word; host_ack pulses once per host write; copy still completes with 4 words.
- **Timeout:** TIMEOUT=8, src_ack never asserted → src_req high for 8 cycles then low; err=1; cpu_rst_n=0; no initram_stb.
- **Zero length and restart:** start with len=0 → done=1 with no writes. A second start with len=2 → done and cpu_rst_n drop to 0, then rise after 2 writes.
- **Wrap and mid-copy reset:** DST_BASE=0xFFFF_FFF8, len=3 → writes at FFF8, FFFC, 0000. Assert rst_n low during the 2nd FETCH → all outputs 0 asynchronously.

Source files
------------

// File: rtl/qmem_boot_seq_if.sv
// Signal bundle for the QMEM boot sequencer: copy control, boot source,
// debug host write port, QMEM initram write port and status.
interface qmem_boot_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             src_req;
  logic [31:0]      src_addr;
  logic             src_ack;
  logic [31:0]      src_data;
  logic             host_stb;
  logic [31:0]      host_addr;
  logic [31:0]      host_data;
  logic [3:0]       host_byte_en;
  logic             host_ack;
  logic             initram_stb;
  logic [31:0]      initram_addr;
  logic [31:0]      initram_data;
  logic [3:0]       initram_byte_en;
  logic             busy;
  logic             done;
  logic             err;
  logic             cpu_rst_n;

  modport master (
    output start, len, src_ack, src_data, host_stb, host_addr, host_data, host_byte_en,
    input  src_req, src_addr, host_ack, initram_stb, initram_addr, initram_data,
           initram_byte_en, busy, done, err, cpu_rst_n
  );

  modport slave (
    input  start, len, src_ack, src_data, host_stb, host_addr, host_data, host_byte_en,
    output src_req, src_addr, host_ack, initram_stb, initram_addr, initram_data,
           initram_byte_en, busy, done, err, cpu_rst_n
  );
endinterface

// File: rtl/qmem_boot_seq.sv
// Boot sequencer: copies a block of boot-source words into QMEM over the initram
// port, interleaves debug-host writes and holds the CPU in reset until the copy is done.
module qmem_boot_seq #(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0000_0000,
  parameter int          CNT_W    = 16,
  parameter int          TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  qmem_boot_seq_if.slave bus
);
  // state | meaning
  // IDLE  | after reset, waiting for start or a host write; CPU held in reset
  // FETCH | src_req raised, waiting for src_ack or timeout
  // WRITE | one-cycle initram write of the fetched word
  // HOST  | one-cycle initram write on behalf of the debug host
  // DONE  | copy finished, CPU released
  // ERR   | source timed out, CPU held in reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_HOST,
    S_DONE,
    S_ERR
  } state_t;

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t           state;
  state_t           ret_state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_inc;
  logic [TMR_W-1:0] timer;

  assign idx_inc = idx + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      ret_state           <= S_IDLE;
      len_q               <= '0;
      idx                 <= '0;
      timer               <= '0;
      bus.src_req         <= 1'b0;
      bus.src_addr        <= '0;
      bus.host_ack        <= 1'b0;
      bus.initram_stb     <= 1'b0;
      bus.initram_addr    <= '0;
      bus.initram_data    <= '0;
      bus.initram_byte_en <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.err             <= 1'b0;
      bus.cpu_rst_n       <= 1'b0;
    end else begin
      bus.initram_stb <= 1'b0;
      bus.host_ack    <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            len_q   <= bus.len;
            idx     <= '0;
            timer   <= '0;
            bus.err <= 1'b0;
            if (bus.len == '0) begin
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.cpu_rst_n <= 1'b1;
            end else begin
              state         <= S_FETCH;
              bus.done      <= 1'b0;
              bus.cpu_rst_n <= 1'b0;
              bus.busy      <= 1'b1;
              bus.src_req   <= 1'b1;
              bus.src_addr  <= SRC_BASE;
            end
          end else if (bus.host_stb) begin
            // Remember where we came from so status bits survive the host write.
            state               <= S_HOST;
            ret_state           <= state;
            bus.initram_stb     <= 1'b1;
            bus.initram_addr    <= bus.host_addr;
            bus.initram_data    <= bus.host_data;
            bus.initram_byte_en <= bus.host_byte_en;
            bus.host_ack        <= 1'b1;
          end
        end

        S_FETCH: begin
          if (bus.src_ack) begin
            state               <= S_WRITE;
            timer               <= '0;
            bus.src_req         <= 1'b0;
            bus.initram_stb     <= 1'b1;
            bus.initram_addr    <= DST_BASE + (32'(idx) << 2);
            bus.initram_data    <= bus.src_data;
            bus.initram_byte_en <= 4'hF;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            state       <= S_ERR;
            timer       <= '0;
            bus.src_req <= 1'b0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_WRITE: begin
          idx <= idx_inc;
          if (idx_inc == len_q) begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.cpu_rst_n <= 1'b1;
          end else if (bus.host_stb) begin
            state               <= S_HOST;
            ret_state           <= S_FETCH;
            bus.initram_stb     <= 1'b1;
            bus.initram_addr    <= bus.host_addr;
            bus.initram_data    <= bus.host_data;
            bus.initram_byte_en <= bus.host_byte_en;
            bus.host_ack        <= 1'b1;
          end else begin
            state        <= S_FETCH;
            bus.src_req  <= 1'b1;
            bus.src_addr <= SRC_BASE + (32'(idx_inc) << 2);
          end
        end

        S_HOST: begin
          if (ret_state == S_FETCH) begin
            state        <= S_FETCH;
            bus.src_req  <= 1'b1;
            bus.src_addr <= SRC_BASE + (32'(idx) << 2);
          end else begin
            state <= ret_state;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qmem_boot_seq.sv
// Bench for qmem_boot_seq: directed and randomized copies compared against a
// transaction-level model of the expected initram write stream and timing.
module tb_qmem_boot_seq;
  localparam int          CNT_W = 16;
  localparam int          TMO   = 8;
  localparam logic [31:0] SRC_A = 32'h0000_0100;
  localparam logic [31:0] DST_A = 32'h0000_2000;
  localparam logic [31:0] SRC_B = 32'h0000_0000;
  localparam logic [31:0] DST_B = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk     = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk = ~clk;

  qmem_boot_seq_if #(.CNT_W(CNT_W)) a ();
  qmem_boot_seq_if #(.CNT_W(CNT_W)) b ();

  qmem_boot_seq #(.SRC_BASE(SRC_A), .DST_BASE(DST_A), .CNT_W(CNT_W), .TIMEOUT(TMO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (a.slave)
  );

  qmem_boot_seq #(.SRC_BASE(SRC_B), .DST_BASE(DST_B), .CNT_W(CNT_W), .TIMEOUT(TMO)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (b.slave)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [95:0] obs, logic [95:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Boot source responder, host driver and initram monitor for instance a
  logic [31:0] src_mem_a [64];
  bit  ack_en     = 1'b1;
  bit  ack_rand   = 1'b0;
  int  cur_dly    = 2;
  int  wait_cnt   = 0;
  int  word_no    = 0;
  int  dly_sum    = 0;
  int  req_cycles = 0;
  int  host_acks  = 0;
  wr_t obs_a[$];
  wr_t host_q[$];

  initial begin
    a.src_ack = 1'b0; a.src_data = '0;
    a.host_stb = 1'b0; a.host_addr = '0; a.host_data = '0; a.host_byte_en = '0;
    forever begin
      @(negedge clk);
      if (a.initram_stb) obs_a.push_back({a.initram_addr, a.initram_data, a.initram_byte_en});
      if (a.host_ack) begin
        host_acks++;
        if (host_q.size() > 0) void'(host_q.pop_front());
      end
      if (host_q.size() > 0) begin
        a.host_stb = 1'b1; a.host_addr = host_q[0].addr;
        a.host_data = host_q[0].data; a.host_byte_en = host_q[0].be;
      end else begin
        a.host_stb = 1'b0;
      end
      if (a.src_req) req_cycles++;
      if (a.src_req && ack_en && !a.src_ack) begin
        if (wait_cnt == cur_dly) begin
          check($sformatf("src_addr%0d", word_no), 96'(a.src_addr), 96'(SRC_A + 32'(word_no) * 32'd4));
          a.src_ack  = 1'b1;
          a.src_data = src_mem_a[word_no];
          dly_sum   += cur_dly + 2;
          word_no++;
          wait_cnt   = 0;
          cur_dly    = ack_rand ? int'($urandom_range(0, 3)) : 2;
        end else begin
          wait_cnt++;
        end
      end else begin
        a.src_ack = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Zero-wait responder and monitor for the wrap instance
  wr_t obs_b[$];
  int  wno_b = 0;
  initial begin
    b.src_ack = 1'b0; b.src_data = '0;
    b.host_stb = 1'b0; b.host_addr = '0; b.host_data = '0; b.host_byte_en = '0;
    forever begin
      @(negedge clk);
      if (b.initram_stb) obs_b.push_back({b.initram_addr, b.initram_data, b.initram_byte_en});
      if (b.src_req && !b.src_ack) begin
        b.src_ack  = 1'b1;
        b.src_data = 32'hC0DE_0000 + 32'(wno_b);
        wno_b++;
      end else begin
        b.src_ack = 1'b0;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_a(int n);
    a.start = 1'b1;
    a.len   = CNT_W'(n);
    step();
    a.start = 1'b0;
  endtask

  // Copies n words with nhost queued host writes held from the start cycle.
  task automatic run_copy(string tag, int n, int nhost, bit rnd);
    wr_t exp_q[$];
    wr_t hlist[$];
    int  hi;
    int  start_cyc;
    int  done_cyc;
    int  lat_exp;
    for (int k = 0; k < n; k++) src_mem_a[k] = $urandom();
    for (int k = 0; k < nhost; k++) begin
      if (rnd) hlist.push_back({$urandom(), $urandom(), 4'($urandom_range(1, 15))});
      else     hlist.push_back({32'h0000_3000, 32'hDEAD_BEEF, 4'b0011});
    end
    obs_a.delete(); word_no = 0; dly_sum = 0; host_acks = 0; wait_cnt = 0;
    ack_en = 1'b1; ack_rand = rnd; cur_dly = rnd ? int'($urandom_range(0, 3)) : 2;
    host_q = hlist;
    step();
    start_a(n);
    start_cyc = cyc;
    check({tag, "_started"}, 96'({a.busy, a.done, a.err, a.cpu_rst_n}), 96'(4'b1000));
    done_cyc = -1;
    for (int i = 0; i < 400 && (done_cyc < 0 || host_q.size() > 0); i++) begin
      if (a.done && done_cyc < 0) done_cyc = cyc;
      step();
    end
    check({tag, "_finished"}, 96'(done_cyc >= 0 && host_q.size() == 0), 96'(1));
    hi = 0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({DST_A + 32'(k) * 32'd4, src_mem_a[k], 4'hF});
      if (k < n - 1 && hi < nhost) begin
        exp_q.push_back(hlist[hi]);
        hi++;
      end
    end
    while (hi < nhost) begin
      exp_q.push_back(hlist[hi]);
      hi++;
    end
    lat_exp = dly_sum + ((nhost < n - 1) ? nhost : n - 1);
    check({tag, "_latency"}, 96'(done_cyc - start_cyc), 96'(lat_exp));
    check({tag, "_nwrites"}, 96'(obs_a.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 96'(obs_a[i]), 96'(exp_q[i]));
    check({tag, "_host_acks"}, 96'(host_acks), 96'(nhost));
    step(2);
    check({tag, "_final"}, 96'({a.busy, a.done, a.err, a.cpu_rst_n, a.initram_stb}), 96'(5'b01010));
  endtask

  initial begin
    wr_t hw;
    int  err_cyc;
    a.start = 1'b0; a.len = '0;
    b.start = 1'b0; b.len = '0;

    // Reset values
    step(2);
    check("rst_ctl_a", 96'({a.src_req, a.host_ack, a.initram_stb, a.busy, a.done, a.err,
                            a.cpu_rst_n, a.initram_byte_en}), 96'(0));
    check("rst_bus_a", {a.src_addr, a.initram_addr, a.initram_data}, 96'(0));
    check("rst_ctl_b", 96'({b.src_req, b.host_ack, b.initram_stb, b.busy, b.done, b.err,
                            b.cpu_rst_n, b.initram_byte_en}), 96'(0));
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    step(2);

    // Host write from IDLE
    obs_a.delete(); host_acks = 0;
    hw = {32'h0000_0040, $urandom(), 4'b1100};
    host_q.push_back(hw);
    for (int i = 0; i < 10 && host_acks < 1; i++) step();
    step();
    check("idle_host_acks", 96'(host_acks), 96'(1));
    check("idle_host_wr", 96'(obs_a.size() > 0 ? obs_a[0] : '0), 96'(hw));
    check("idle_host_status", 96'({a.busy, a.done, a.err, a.cpu_rst_n}), 96'(0));

    run_copy("basic", 4, 0, 1'b0);
    run_copy("host", 4, 4, 1'b0);

    // Source timeout
    obs_a.delete(); req_cycles = 0; ack_en = 1'b0;
    start_a(3);
    err_cyc = cyc;
    for (int i = 0; i < 40 && !a.err; i++) step();
    check("tmo_req_cycles", 96'(req_cycles), 96'(TMO));
    check("tmo_err_time", 96'(cyc - err_cyc), 96'(TMO));
    check("tmo_status", 96'({a.err, a.done, a.cpu_rst_n, a.busy, a.src_req}), 96'(5'b10000));
    step(5);
    check("tmo_sticky", 96'({a.err, a.cpu_rst_n}), 96'(2'b10));
    check("tmo_no_writes", 96'(obs_a.size()), 96'(0));

    // Zero length from ERR, then restart
    ack_en = 1'b1;
    start_a(0);
    check("zero_status", 96'({a.done, a.err, a.cpu_rst_n, a.busy}), 96'(4'b1010));
    step(3);
    check("zero_no_writes", 96'(obs_a.size()), 96'(0));
    run_copy("restart", 2, 0, 1'b1);

    for (int r = 0; r < 4; r++)
      run_copy($sformatf("rand%0d", r), int'($urandom_range(1, 6)), int'($urandom_range(0, 4)), 1'b1);

    // Destination wrap on the second instance
    obs_b.delete(); wno_b = 0;
    b.start = 1'b1; b.len = CNT_W'(3);
    step();
    b.start = 1'b0;
    for (int i = 0; i < 40 && !b.done; i++) step();
    check("wrap_nwrites", 96'(obs_b.size()), 96'(3));
    for (int k = 0; k < 3 && k < obs_b.size(); k++)
      check($sformatf("wrap_wr%0d", k), 96'(obs_b[k]),
            96'({DST_B + 32'(k) * 32'd4, 32'hC0DE_0000 + 32'(k), 4'hF}));
    check("wrap_cpu_rel", 96'({b.done, b.cpu_rst_n}), 96'(2'b11));

    // Asynchronous reset during the second fetch
    obs_b.delete(); wno_b = 0;
    b.start = 1'b1; b.len = CNT_W'(3);
    step();
    b.start = 1'b0;
    for (int i = 0; i < 20 && !(obs_b.size() >= 1 && b.src_req); i++) step();
    check("wrap_fetch2", 96'({b.src_req, b.src_addr}), 96'({1'b1, SRC_B + 32'd4}));
    #2;
    rst_n_b = 1'b0;
    #1;
    check("midrst_ctl", 96'({b.src_req, b.host_ack, b.initram_stb, b.busy, b.done, b.err,
                             b.cpu_rst_n, b.initram_byte_en}), 96'(0));
    check("midrst_bus", {b.src_addr, b.initram_addr, b.initram_data}, 96'(0));
    step();
    rst_n_b = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
